descrambler_lfsr_nlane: RTL and testbench

Multi-lane, multi-byte-per-clock PCIe Gen1/Gen2 descrambler for the RX second half. It is the parametrised successor of the single-lane 8-bit LFSR stage. Each lane keeps its own x^16+x^5+x^4+x^3+1 LFSR and applies 8b/10b-era scrambling rules per symbol: COM reinitialises the LFSR, SKP freezes it, other K symbols advance without being XORed, and D symbols are XORed and advance. It sits between the lane deskew buffer and the ordered-set / TLP-DLLP parser and adds one registered pipeline stage.

---
 rtl/descrambler_lfsr_nlane_if.sv | 22 ++
 rtl/descrambler_lfsr_nlane.sv | 93 +++++++++
 tb/tb_descrambler_lfsr_nlane.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/descrambler_lfsr_nlane_if.sv
// rtl/descrambler_lfsr_nlane_if.sv - beat stream bundle between deskew buffer, descrambler and parser
interface descrambler_lfsr_nlane_if #(
    parameter int LANES = 4,
    parameter int BPL   = 1
);
    logic                      in_valid;
    logic [LANES*BPL*8-1:0]    in_data;
    logic [LANES*BPL-1:0]      in_k;
    logic                      out_valid;
    logic [LANES*BPL*8-1:0]    out_data;
    logic [LANES*BPL-1:0]      out_k;

    modport master (
        output in_valid, in_data, in_k,
        input  out_valid, out_data, out_k
    );

    modport slave (
        input  in_valid, in_data, in_k,
        output out_valid, out_data, out_k
    );
endinterface

// File: rtl/descrambler_lfsr_nlane.sv
// rtl/descrambler_lfsr_nlane.sv - per-lane x^16+x^5+x^4+x^3+1 descrambler, BPL bytes per lane per clock
module descrambler_lfsr_nlane #(
    parameter int          LANES = 4,
    parameter int          BPL   = 1,
    parameter logic [15:0] SEED  = 16'hFFFF
) (
    input  logic                   TX_CLK,
    input  logic                   rst,
    input  logic                   LFSR_RST,
    input  logic [LANES-1:0]       lane_en,
    input  logic                   scr_dis,
    descrambler_lfsr_nlane_if.slave s_if,
    output logic [LANES*16-1:0]    lfsr_state
);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;

    logic [LANES-1:0][15:0]     lfsr_q;
    logic [LANES-1:0][15:0]     nxt_state;
    logic [LANES*BPL*8-1:0]     nxt_data;
    logic [15:0]                cur;
    logic [7:0]                 sym;
    logic                       sym_k;

    function automatic logic [15:0] step1(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    endfunction

    // Unrolled eight Galois steps; synthesis flattens this to a closed-form XOR network.
    function automatic logic [15:0] adv8(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = step1(t);
        end
        return t;
    endfunction

    // Feedback taps never reach the top byte within eight steps, so the key is s[15:8] reversed.
    function automatic logic [7:0] key_of(input logic [15:0] s);
        logic [7:0] kb;
        for (int i = 0; i < 8; i++) begin
            kb[i] = s[15-i];
        end
        return kb;
    endfunction

    always_comb begin
        nxt_data  = s_if.in_data;
        nxt_state = lfsr_q;
        cur       = SEED;
        sym       = 8'h00;
        sym_k     = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            cur = LFSR_RST ? SEED : lfsr_q[l];
            if (s_if.in_valid && lane_en[l]) begin
                for (int b = 0; b < BPL; b++) begin
                    sym   = s_if.in_data[(l*BPL+b)*8 +: 8];
                    sym_k = s_if.in_k[l*BPL+b];
                    if (sym_k && sym == SYM_COM) begin
                        cur = SEED;
                    end else if (!(sym_k && sym == SYM_SKP)) begin
                        if (!sym_k && !scr_dis) begin
                            nxt_data[(l*BPL+b)*8 +: 8] = sym ^ key_of(cur);
                        end
                        cur = adv8(cur);
                    end
                end
            end
            nxt_state[l] = cur;
        end
    end

    always_ff @(posedge TX_CLK or negedge rst) begin
        if (!rst) begin
            s_if.out_valid <= 1'b0;
            s_if.out_data  <= '0;
            s_if.out_k     <= '0;
            lfsr_q         <= {LANES{SEED}};
        end else begin
            s_if.out_valid <= s_if.in_valid;
            if (s_if.in_valid) begin
                s_if.out_data <= nxt_data;
                s_if.out_k    <= s_if.in_k;
            end
            lfsr_q <= nxt_state;
        end
    end

    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_descrambler_lfsr_nlane.sv
// tb/tb_descrambler_lfsr_nlane.sv - directed bench for descrambler_lfsr_nlane (1x1 and 4x2 instances)
module tb_descrambler_lfsr_nlane;

    localparam logic [15:0] SEED = 16'hFFFF;

    logic        TX_CLK = 1'b0;
    logic        rst;
    logic        lrst1, lrst4;
    logic [0:0]  en1;
    logic [3:0]  en4;
    logic        sd1, sd4;
    logic [15:0] st1;
    logic [63:0] st4;

    logic [15:0] mst1;
    logic [15:0] mst4 [4];

    int passed = 0;
    int total  = 0;

    always #5 TX_CLK = ~TX_CLK;

    descrambler_lfsr_nlane_if #(.LANES(1), .BPL(1)) if1 ();
    descrambler_lfsr_nlane_if #(.LANES(4), .BPL(2)) if4 ();

    descrambler_lfsr_nlane #(.LANES(1), .BPL(1), .SEED(SEED)) u1 (
        .TX_CLK(TX_CLK), .rst(rst), .LFSR_RST(lrst1), .lane_en(en1),
        .scr_dis(sd1), .s_if(if1.slave), .lfsr_state(st1)
    );

    descrambler_lfsr_nlane #(.LANES(4), .BPL(2), .SEED(SEED)) u4 (
        .TX_CLK(TX_CLK), .rst(rst), .LFSR_RST(lrst4), .lane_en(en4),
        .scr_dis(sd4), .s_if(if4.slave), .lfsr_state(st4)
    );

    function automatic logic [15:0] mstep(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    endfunction

    // Bit-serial reference: each key bit is s[15] taken before that step.
    task automatic mbyte(input logic [7:0] d, input logic k, input logic sd,
                         inout logic [15:0] s, output logic [7:0] o);
        o = d;
        if (k && d == 8'hBC) begin
            s = SEED;
        end else if (!(k && d == 8'h1C)) begin
            for (int i = 0; i < 8; i++) begin
                if (!k && !sd) o[i] = d[i] ^ s[15];
                s = mstep(s);
            end
        end
    endtask

    task automatic tick;
        @(posedge TX_CLK);
        #1;
    endtask

    task automatic beat4(input logic [63:0] d, input logic [7:0] k,
                         output logic [63:0] e, output logic [63:0] es);
        logic [15:0] s;
        logic [7:0]  o;
        if4.in_valid = 1'b1;
        if4.in_data  = d;
        if4.in_k     = k;
        for (int l = 0; l < 4; l++) begin
            s = lrst4 ? SEED : mst4[l];
            for (int b = 0; b < 2; b++) begin
                if (en4[l]) mbyte(d[(l*2+b)*8 +: 8], k[l*2+b], sd4, s, o);
                else        o = d[(l*2+b)*8 +: 8];
                e[(l*2+b)*8 +: 8] = o;
            end
            mst4[l] = s;
            es[l*16 +: 16] = s;
        end
    endtask

    task automatic beat1(input logic [7:0] d, input logic k, output logic [7:0] e);
        logic [15:0] s;
        if1.in_valid = 1'b1;
        if1.in_data  = d;
        if1.in_k     = k;
        s = lrst1 ? SEED : mst1;
        if (en1[0]) mbyte(d, k, sd1, s, e);
        else        e = d;
        mst1 = s;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        if1.in_valid = 0; if1.in_data = '0; if1.in_k = '0;
        if4.in_valid = 0; if4.in_data = '0; if4.in_k = '0;
        lrst1 = 0; lrst4 = 0; en1 = 1'b1; en4 = 4'hF; sd1 = 0; sd4 = 0;
        tick; tick;
        total++; if (if1.out_valid !== 1'b0) $display("FAIL rst_u1_valid: got %b want 0", if1.out_valid); else passed++;
        total++; if (if1.out_data !== 8'h00) $display("FAIL rst_u1_data: got %h want 00", if1.out_data); else passed++;
        total++; if (st1 !== SEED) $display("FAIL rst_u1_state: got %h want %h", st1, SEED); else passed++;
        total++; if ({if4.out_valid, if4.out_data, if4.out_k} !== 73'd0) $display("FAIL rst_u4_outs: got %b/%h/%h want 0", if4.out_valid, if4.out_data, if4.out_k); else passed++;
        total++; if (st4 !== {4{SEED}}) $display("FAIL rst_u4_state: got %h want %h", st4, {4{SEED}}); else passed++;
        rst = 1'b1;
        mst1 = SEED;
        for (int l = 0; l < 4; l++) mst4[l] = SEED;
    endtask

    task automatic test_single_lane;
        logic [7:0] e;
        beat1(8'h00, 1'b0, e);
        tick;
        total++; if (if1.out_valid !== 1'b1) $display("FAIL sl_valid: got %b want 1", if1.out_valid); else passed++;
        total++; if (if1.out_data !== 8'hFF) $display("FAIL sl_byte0: got %h want ff", if1.out_data); else passed++;
        total++; if (st1 !== 16'hE817) $display("FAIL sl_state0: got %h want e817", st1); else passed++;
        beat1(8'h00, 1'b0, e);
        tick;
        total++; if (if1.out_data !== 8'h17) $display("FAIL sl_byte1: got %h want 17", if1.out_data); else passed++;
        total++; if (st1 !== mst1) $display("FAIL sl_state1: got %h want %h", st1, mst1); else passed++;
        if1.in_valid = 1'b0;
        if1.in_data  = 8'hA5;
        tick;
        total++; if (if1.out_valid !== 1'b0) $display("FAIL sl_idle_valid: got %b want 0", if1.out_valid); else passed++;
        total++; if (if1.out_data !== 8'h17) $display("FAIL sl_idle_hold: got %h want 17", if1.out_data); else passed++;
        total++; if (st1 !== mst1) $display("FAIL sl_idle_state: got %h want %h", st1, mst1); else passed++;
    endtask

    task automatic test_two_byte;
        logic [63:0] e, es;
        beat4(64'h0, 8'h00, e, es);
        total++; if (if4.out_valid !== 1'b0) $display("FAIL tb_pre_valid: got %b want 0", if4.out_valid); else passed++;
        tick;
        total++; if (if4.out_valid !== 1'b1) $display("FAIL tb_valid: got %b want 1", if4.out_valid); else passed++;
        total++; if (if4.out_data !== 64'h17FF17FF17FF17FF) $display("FAIL tb_data: got %h want 17ff17ff17ff17ff", if4.out_data); else passed++;
        total++; if (st4 !== es) $display("FAIL tb_state: got %h want %h", st4, es); else passed++;
        if4.in_valid = 1'b0;
    endtask

    task automatic test_com_skp;
        logic [63:0] e, es;
        beat4({4{16'h1CBC}}, 8'hFF, e, es);
        tick;
        total++; if (if4.out_data !== {4{16'h1CBC}}) $display("FAIL cs_com_data: got %h want %h", if4.out_data, {4{16'h1CBC}}); else passed++;
        total++; if (if4.out_k !== 8'hFF) $display("FAIL cs_com_k: got %h want ff", if4.out_k); else passed++;
        beat4({4{16'h1C1C}}, 8'hFF, e, es);
        tick;
        total++; if (if4.out_data !== {4{16'h1C1C}}) $display("FAIL cs_skp_data: got %h want %h", if4.out_data, {4{16'h1C1C}}); else passed++;
        beat4(64'h0, 8'h00, e, es);
        tick;
        total++; if (if4.out_data !== 64'h17FF17FF17FF17FF) $display("FAIL cs_d_after_skp: got %h want 17ff17ff17ff17ff", if4.out_data); else passed++;
        total++; if (if4.out_k !== 8'h00) $display("FAIL cs_d_k: got %h want 00", if4.out_k); else passed++;
        beat4({4{16'hF7BC}}, 8'hFF, e, es);
        tick;
        beat4({4{16'h1C1C}}, 8'hFF, e, es);
        tick;
        beat4(64'h0, 8'h00, e, es);
        tick;
        total++; if (if4.out_data[7:0] !== 8'h17) $display("FAIL cs_otherk_byte: got %h want 17", if4.out_data[7:0]); else passed++;
        total++; if (if4.out_data !== e) $display("FAIL cs_otherk_data: got %h want %h", if4.out_data, e); else passed++;
        total++; if (st4 !== es) $display("FAIL cs_otherk_state: got %h want %h", st4, es); else passed++;
        if4.in_valid = 1'b0;
    endtask

    task automatic test_lfsr_rst;
        logic [63:0] e, es;
        beat4({$urandom, $urandom}, 8'h00, e, es);
        tick;
        total++; if (if4.out_data !== e) $display("FAIL lr_pre_data: got %h want %h", if4.out_data, e); else passed++;
        lrst4 = 1'b1;
        beat4(64'h0, 8'h00, e, es);
        tick;
        total++; if (if4.out_data !== 64'h17FF17FF17FF17FF) $display("FAIL lr_valid_data: got %h want 17ff17ff17ff17ff", if4.out_data); else passed++;
        total++; if (st4 !== es) $display("FAIL lr_valid_state: got %h want %h", st4, es); else passed++;
        if4.in_valid = 1'b0;
        tick;
        total++; if (st4 !== {4{SEED}}) $display("FAIL lr_idle_state: got %h want %h", st4, {4{SEED}}); else passed++;
        total++; if (if4.out_data !== 64'h17FF17FF17FF17FF) $display("FAIL lr_idle_hold: got %h want 17ff17ff17ff17ff", if4.out_data); else passed++;
        lrst4 = 1'b0;
        for (int l = 0; l < 4; l++) mst4[l] = SEED;
    endtask

    task automatic test_lane_en;
        logic [63:0] e, es;
        en4 = 4'b1010;
        for (int n = 0; n < 6; n++) begin
            beat4({$urandom, $urandom}, 8'h00, e, es);
            tick;
            total++; if (if4.out_data !== e) $display("FAIL le_data[%0d]: got %h want %h", n, if4.out_data, e); else passed++;
            total++; if (st4 !== es) $display("FAIL le_state[%0d]: got %h want %h", n, st4, es); else passed++;
        end
        total++; if ({st4[47:32], st4[15:0]} !== {SEED, SEED}) $display("FAIL le_frozen: got %h want %h", {st4[47:32], st4[15:0]}, {SEED, SEED}); else passed++;
        if4.in_valid = 1'b0;
        en4 = 4'hF;
    endtask

    task automatic test_rst_mid;
        logic [63:0] e, es;
        beat4({$urandom, $urandom}, 8'h00, e, es);
        tick;
        beat4({$urandom, $urandom}, 8'h00, e, es);
        rst = 1'b0;
        #1;
        total++; if ({if4.out_valid, if4.out_data, if4.out_k} !== 73'd0) $display("FAIL rm_outs: got %b/%h/%h want 0", if4.out_valid, if4.out_data, if4.out_k); else passed++;
        total++; if (st4 !== {4{SEED}}) $display("FAIL rm_state: got %h want %h", st4, {4{SEED}}); else passed++;
        tick;
        total++; if ({if4.out_valid, if4.out_data} !== 65'd0) $display("FAIL rm_held: got %b/%h want 0", if4.out_valid, if4.out_data); else passed++;
        rst = 1'b1;
        for (int l = 0; l < 4; l++) mst4[l] = SEED;
        mst1 = SEED;
        beat4(64'h0, 8'h00, e, es);
        tick;
        total++; if (if4.out_data !== 64'h17FF17FF17FF17FF) $display("FAIL rm_first: got %h want 17ff17ff17ff17ff", if4.out_data); else passed++;
        total++; if (if4.out_valid !== 1'b1) $display("FAIL rm_valid: got %b want 1", if4.out_valid); else passed++;
        if4.in_valid = 1'b0;
    endtask

    task automatic test_scr_dis;
        logic [7:0] d, e;
        lrst1 = 1'b1;
        if1.in_valid = 1'b0;
        tick;
        lrst1 = 1'b0;
        mst1 = SEED;
        total++; if (st1 !== SEED) $display("FAIL sd_seed: got %h want %h", st1, SEED); else passed++;
        sd1 = 1'b1;
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            beat1(d, 1'b0, e);
            tick;
            total++; if (if1.out_data !== d) $display("FAIL sd_pass[%0d]: got %h want %h", n, if1.out_data, d); else passed++;
        end
        total++; if (st1 !== mst1) $display("FAIL sd_tracked: got %h want %h", st1, mst1); else passed++;
        sd1 = 1'b0;
        beat1(8'h00, 1'b0, e);
        tick;
        total++; if (if1.out_data !== e) $display("FAIL sd_resume: got %h want %h", if1.out_data, e); else passed++;
        if1.in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_lane;
        test_two_byte;
        test_com_skp;
        test_lfsr_rst;
        test_lane_en;
        test_rst_mid;
        test_scr_dis;
        tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
